parallel_data_mem: RTL and testbench

PARALLEL_DATA_MEM -- requirements
Module: parallel_data_mem

---
 rtl/parallel_data_mem_pkg.sv | 19 +
 rtl/parallel_data_mem_bank.sv | 41 ++++
 rtl/parallel_data_mem.sv | 185 ++++++++++++++++++
 tb/tb_parallel_data_mem.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_data_mem_pkg.sv
// -----------------------------------------------------------------------------
// parallel_data_mem_pkg
// Shared definitions for the parallel data memory:
//   state_t  - controller FSM encoding (IDLE / RUN / DONE)
//   lane_w() - width of a lane index for a given lane count (never below 1)
// -----------------------------------------------------------------------------
package parallel_data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parallel_data_mem_bank.sv
// -----------------------------------------------------------------------------
// data_mem_bank
// Single-port RAM, REG_WIDTH x 2**ADDR_WIDTH, one registered read port.
// Read-first: a write returns the previous contents of the addressed word.
// Contents and the read register have no reset.
// Ports:
//   i_clk   - clock, rising edge
//   i_en    - access enable (read, or read+write when i_we=1)
//   i_we    - write enable, qualified by i_en
//   i_addr  - word address
//   i_wdata - write data
//   o_rdata - read data, valid the cycle after an enabled access
// -----------------------------------------------------------------------------
module data_mem_bank #(
    parameter int REG_WIDTH  = 12,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [REG_WIDTH-1:0]  i_wdata,
    output logic [REG_WIDTH-1:0]  o_rdata
);

    logic [REG_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [REG_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            // Sampled before the write above lands: old data on collision.
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/parallel_data_mem.sv
// -----------------------------------------------------------------------------
// parallel_data_mem
// CORE_COUNT banks of data memory shared between a host and a SIMD processor.
// In RUN the processor drives all banks in lockstep (one address, one lane per
// bank); in IDLE/DONE the host accesses one lane at a time.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - host launch request
//   procStart         - one-cycle launch pulse to the processor
//   procDone          - processor completion flag
//   dataMemAddr       - processor shared address
//   DataMemWrEn       - processor write enable (all lanes)
//   ProcessorDataOut  - processor write data, lane i at [REG_WIDTH*i +: REG_WIDTH]
//   ProcessorDataIn   - processor read data (latency 1), same packing
//   hostWrEn/hostRdEn - host write / read strobes
//   hostAddr/hostLane - host address and lane select
//   hostWrData        - host write data
//   hostRdData        - host read data, holds between reads
//   hostRdValid       - one-cycle pulse when hostRdData carries new read data
//   busy / finished   - state is RUN / DONE
//   hostErr           - sticky: host access in RUN or to a nonexistent lane
// Handshake: no back-pressure. A host read accepted on edge N presents
// hostRdData with hostRdValid=1 during the cycle after edge N; a processor
// access on edge N presents ProcessorDataIn during the cycle after edge N.
// -----------------------------------------------------------------------------
module parallel_data_mem
    import parallel_data_mem_pkg::*;
#(
    parameter int REG_WIDTH           = 12,
    parameter int CORE_COUNT          = 4,
    parameter int DATA_MEM_ADDR_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                procStart,
    input  logic                                procDone,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0]      dataMemAddr,
    input  logic                                DataMemWrEn,
    input  logic [REG_WIDTH*CORE_COUNT-1:0]     ProcessorDataOut,
    output logic [REG_WIDTH*CORE_COUNT-1:0]     ProcessorDataIn,
    input  logic                                hostWrEn,
    input  logic                                hostRdEn,
    input  logic [DATA_MEM_ADDR_WIDTH-1:0]      hostAddr,
    input  logic [lane_w(CORE_COUNT)-1:0]       hostLane,
    input  logic [REG_WIDTH-1:0]                hostWrData,
    output logic [REG_WIDTH-1:0]                hostRdData,
    output logic                                hostRdValid,
    output logic                                busy,
    output logic                                finished,
    output logic                                hostErr
);

    localparam int LW = lane_w(CORE_COUNT);

    // ---------------- controller FSM ----------------
    state_t r_state;
    state_t w_state_next;
    logic   r_proc_start;
    logic   r_busy;
    logic   r_finished;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)    w_state_next = ST_RUN;
            ST_RUN:  if (procDone) w_state_next = ST_DONE;
            ST_DONE: if (start)    w_state_next = ST_RUN;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_proc_start <= 1'b0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_proc_start <= (w_state_next == ST_RUN) && (r_state != ST_RUN);
            r_busy       <= (w_state_next == ST_RUN);
            r_finished   <= (w_state_next == ST_DONE);
        end
    end

    assign procStart = r_proc_start;
    assign busy      = r_busy;
    assign finished  = r_finished;

    // ---------------- bank ownership ----------------
    logic w_run;
    logic w_host_req;
    logic w_lane_ok;
    logic w_host_go;

    assign w_run      = (r_state == ST_RUN);
    assign w_host_req = hostWrEn | hostRdEn;
    assign w_lane_ok  = (int'(hostLane) < CORE_COUNT);
    assign w_host_go  = w_host_req & w_lane_ok & ~w_run;

    logic [CORE_COUNT-1:0]          w_bank_en;
    logic [CORE_COUNT-1:0]          w_bank_we;
    logic [DATA_MEM_ADDR_WIDTH-1:0] w_bank_addr  [CORE_COUNT];
    logic [REG_WIDTH-1:0]           w_bank_wdata [CORE_COUNT];
    logic [REG_WIDTH-1:0]           w_bank_rdata [CORE_COUNT];
    logic [REG_WIDTH-1:0]           r_proc_hold  [CORE_COUNT];
    logic                           r_proc_rd_d;

    for (genvar g = 0; g < CORE_COUNT; g++) begin : g_bank
        assign w_bank_en[g]    = w_run | (w_host_go & (hostLane == LW'(g)));
        assign w_bank_we[g]    = w_run ? DataMemWrEn : hostWrEn;
        assign w_bank_addr[g]  = w_run ? dataMemAddr : hostAddr;
        assign w_bank_wdata[g] = w_run ? ProcessorDataOut[REG_WIDTH*g +: REG_WIDTH]
                                       : hostWrData;

        data_mem_bank #(
            .REG_WIDTH  (REG_WIDTH),
            .ADDR_WIDTH (DATA_MEM_ADDR_WIDTH)
        ) u_bank (
            .i_clk   (clk),
            .i_en    (w_bank_en[g]),
            .i_we    (w_bank_we[g]),
            .i_addr  (w_bank_addr[g]),
            .i_wdata (w_bank_wdata[g]),
            .o_rdata (w_bank_rdata[g])
        );

        // Bank read registers are shared with host traffic, so the processor
        // view shows the bank only in the cycle after a processor access and a
        // captured copy otherwise.
        assign ProcessorDataIn[REG_WIDTH*g +: REG_WIDTH] =
            r_proc_rd_d ? w_bank_rdata[g] : r_proc_hold[g];
    end

    // ---------------- host read path ----------------
    logic              r_host_rd_d;
    logic [LW-1:0]     r_host_lane_d;
    logic [REG_WIDTH-1:0] r_host_hold;
    logic [REG_WIDTH-1:0] w_host_sel_rdata;
    logic              r_host_err;

    always_comb begin
        w_host_sel_rdata = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (r_host_lane_d == LW'(i)) begin
                w_host_sel_rdata = w_bank_rdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_proc_rd_d   <= 1'b0;
            r_host_rd_d   <= 1'b0;
            r_host_lane_d <= '0;
            r_host_hold   <= '0;
            r_host_err    <= 1'b0;
            for (int i = 0; i < CORE_COUNT; i++) begin
                r_proc_hold[i] <= '0;
            end
        end else begin
            r_proc_rd_d <= w_run;
            if (r_proc_rd_d) begin
                for (int i = 0; i < CORE_COUNT; i++) begin
                    r_proc_hold[i] <= w_bank_rdata[i];
                end
            end
            // A simultaneous write wins; the read is dropped.
            r_host_rd_d   <= w_host_go & hostRdEn & ~hostWrEn;
            r_host_lane_d <= hostLane;
            if (r_host_rd_d) begin
                r_host_hold <= w_host_sel_rdata;
            end
            if (w_host_req && (w_run || !w_lane_ok)) begin
                r_host_err <= 1'b1;
            end
        end
    end

    assign hostRdData  = r_host_rd_d ? w_host_sel_rdata : r_host_hold;
    assign hostRdValid = r_host_rd_d;
    assign hostErr     = r_host_err;

endmodule

// File: tb/tb_parallel_data_mem.sv
// -----------------------------------------------------------------------------
// tb_parallel_data_mem
// Directed bench for parallel_data_mem. Instance u_dut uses the default
// parameters; instance u_dut3 uses CORE_COUNT=3 so that an out-of-range lane
// index is expressible on a 2-bit hostLane.
// -----------------------------------------------------------------------------
module tb_parallel_data_mem;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (defaults: 12-bit, 4 lanes, 12-bit address) ----------------
    logic        start, procDone, DataMemWrEn, hostWrEn, hostRdEn;
    logic [11:0] dataMemAddr, hostAddr, hostWrData;
    logic [47:0] ProcessorDataOut;
    logic [1:0]  hostLane;
    logic        procStart, hostRdValid, busy, finished, hostErr;
    logic [47:0] ProcessorDataIn;
    logic [11:0] hostRdData;

    parallel_data_mem u_dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .procStart        (procStart),
        .procDone         (procDone),
        .dataMemAddr      (dataMemAddr),
        .DataMemWrEn      (DataMemWrEn),
        .ProcessorDataOut (ProcessorDataOut),
        .ProcessorDataIn  (ProcessorDataIn),
        .hostWrEn         (hostWrEn),
        .hostRdEn         (hostRdEn),
        .hostAddr         (hostAddr),
        .hostLane         (hostLane),
        .hostWrData       (hostWrData),
        .hostRdData       (hostRdData),
        .hostRdValid      (hostRdValid),
        .busy             (busy),
        .finished         (finished),
        .hostErr          (hostErr)
    );

    // ---------------- DUT3 (8-bit, 3 lanes, 4-bit address) ----------------
    logic        b_hostWrEn, b_hostRdEn;
    logic [3:0]  b_hostAddr;
    logic [1:0]  b_hostLane;
    logic [7:0]  b_hostWrData, b_hostRdData;
    logic        b_procStart, b_hostRdValid, b_busy, b_finished, b_hostErr;
    logic [23:0] b_ProcessorDataIn;

    parallel_data_mem #(
        .REG_WIDTH           (8),
        .CORE_COUNT          (3),
        .DATA_MEM_ADDR_WIDTH (4)
    ) u_dut3 (
        .clk              (clk),
        .rst              (rst),
        .start            (1'b0),
        .procStart        (b_procStart),
        .procDone         (1'b0),
        .dataMemAddr      (4'h0),
        .DataMemWrEn      (1'b0),
        .ProcessorDataOut (24'h0),
        .ProcessorDataIn  (b_ProcessorDataIn),
        .hostWrEn         (b_hostWrEn),
        .hostRdEn         (b_hostRdEn),
        .hostAddr         (b_hostAddr),
        .hostLane         (b_hostLane),
        .hostWrData       (b_hostWrData),
        .hostRdData       (b_hostRdData),
        .hostRdValid      (b_hostRdValid),
        .busy             (b_busy),
        .finished         (b_finished),
        .hostErr          (b_hostErr)
    );

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic proc_acc(input logic we, input logic [11:0] addr, input logic [47:0] data);
        DataMemWrEn      = we;
        dataMemAddr      = addr;
        ProcessorDataOut = data;
        tick();
        DataMemWrEn      = 1'b0;
    endtask

    task automatic host_acc(input logic wr, input logic rd, input logic [1:0] lane,
                            input logic [11:0] addr, input logic [11:0] data);
        hostWrEn   = wr;
        hostRdEn   = rd;
        hostLane   = lane;
        hostAddr   = addr;
        hostWrData = data;
        tick();
        hostWrEn   = 1'b0;
        hostRdEn   = 1'b0;
    endtask

    task automatic b_host_acc(input logic wr, input logic rd, input logic [1:0] lane,
                              input logic [3:0] addr, input logic [7:0] data);
        b_hostWrEn   = wr;
        b_hostRdEn   = rd;
        b_hostLane   = lane;
        b_hostAddr   = addr;
        b_hostWrData = data;
        tick();
        b_hostWrEn   = 1'b0;
        b_hostRdEn   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_procStart"}, 64'(procStart), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_finished"},  64'(finished),  64'd0);
        chk({tag, "_rdvalid"},   64'(hostRdValid), 64'd0);
        chk({tag, "_hostErr"},   64'(hostErr),   64'd0);
        chk({tag, "_rdData"},    64'(hostRdData), 64'd0);
        chk({tag, "_procIn"},    64'(ProcessorDataIn), 64'd0);
    endtask

    localparam logic [47:0] P  = 48'h004_003_002_001;
    localparam logic [47:0] Q  = 48'h0AA_0BB_0CC_0DD;
    localparam logic [47:0] R  = 48'h123_456_789_ABC;
    localparam logic [47:0] Q2 = 48'hFFF_000_FFF_000;

    // ---------------- directed sequence ----------------
    initial begin
        start = 0; procDone = 0; DataMemWrEn = 0; hostWrEn = 0; hostRdEn = 0;
        dataMemAddr = '0; hostAddr = '0; hostWrData = '0; ProcessorDataOut = '0;
        hostLane = '0;
        b_hostWrEn = 0; b_hostRdEn = 0; b_hostAddr = '0; b_hostLane = '0; b_hostWrData = '0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("por");

        // Host preload and readback
        host_acc(1'b1, 1'b0, 2'd2, 12'h010, 12'h5A5);
        chk("preload_wr_novalid", 64'(hostRdValid), 64'd0);
        host_acc(1'b0, 1'b1, 2'd2, 12'h010, 12'h000);
        chk("preload_rd_valid", 64'(hostRdValid), 64'd1);
        chk("preload_rd_data",  64'(hostRdData),  64'h5A5);
        tick();
        chk("preload_valid_pulse", 64'(hostRdValid), 64'd0);
        chk("preload_data_hold",   64'(hostRdData),  64'h5A5);

        // Launch
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("launch_procStart", 64'(procStart), 64'd1);
        chk("launch_busy",      64'(busy),      64'd1);
        tick();
        chk("launch_pulse_end", 64'(procStart), 64'd0);
        chk("launch_busy_hold", 64'(busy),      64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_start_ignored", 64'(procStart), 64'd0);

        // Processor write / read, read-first collision
        proc_acc(1'b1, 12'h020, P);
        proc_acc(1'b0, 12'h020, 48'h0);
        chk("proc_rd_020", 64'(ProcessorDataIn), 64'(P));
        proc_acc(1'b1, 12'h021, Q);
        proc_acc(1'b1, 12'h022, R);
        proc_acc(1'b0, 12'h022, 48'h0);
        chk("proc_rd_022", 64'(ProcessorDataIn), 64'(R));
        proc_acc(1'b1, 12'h021, Q2);
        chk("proc_read_first", 64'(ProcessorDataIn), 64'(Q));
        proc_acc(1'b0, 12'h021, 48'h0);
        chk("proc_rd_021_new", 64'(ProcessorDataIn), 64'(Q2));

        // Host access while running is rejected
        host_acc(1'b1, 1'b0, 2'd2, 12'h010, 12'h0FF);
        chk("run_host_err",     64'(hostErr),     64'd1);
        host_acc(1'b0, 1'b1, 2'd2, 12'h010, 12'h000);
        chk("run_host_novalid", 64'(hostRdValid), 64'd0);

        // Completion
        procDone = 1'b1;
        tick();
        procDone = 1'b0;
        chk("done_finished",  64'(finished), 64'd1);
        chk("done_busy",      64'(busy),     64'd0);
        chk("done_procStart", 64'(procStart), 64'd0);
        proc_acc(1'b1, 12'h020, 48'hEEE_EEE_EEE_EEE);
        tick();
        chk("done_procIn_hold", 64'(ProcessorDataIn), 64'(Q2));
        host_acc(1'b0, 1'b1, 2'd3, 12'h020, 12'h000);
        chk("done_rd_lane3_valid", 64'(hostRdValid), 64'd1);
        chk("done_rd_lane3",       64'(hostRdData),  64'h004);
        host_acc(1'b0, 1'b1, 2'd0, 12'h020, 12'h000);
        chk("done_proc_wr_ignored", 64'(hostRdData), 64'h001);
        host_acc(1'b0, 1'b1, 2'd2, 12'h010, 12'h000);
        chk("run_host_wr_ignored",  64'(hostRdData), 64'h5A5);

        // Write+read together: write lands, no valid
        host_acc(1'b1, 1'b1, 2'd1, 12'h040, 12'h777);
        chk("conflict_novalid", 64'(hostRdValid), 64'd0);
        host_acc(1'b0, 1'b1, 2'd1, 12'h040, 12'h000);
        chk("conflict_wr_landed", 64'(hostRdData), 64'h777);
        // Full address range: top address
        host_acc(1'b1, 1'b0, 2'd0, 12'hFFF, 12'hABC);
        host_acc(1'b0, 1'b1, 2'd0, 12'hFFF, 12'h000);
        chk("top_addr_rd", 64'(hostRdData), 64'hABC);

        // Out-of-range lane on the 3-lane instance
        b_host_acc(1'b1, 1'b0, 2'd0, 4'h5, 8'h3C);
        chk("b_valid_wr_noerr", 64'(b_hostErr), 64'd0);
        b_host_acc(1'b1, 1'b0, 2'd3, 4'h5, 8'hFF);
        chk("b_lane3_err", 64'(b_hostErr), 64'd1);
        b_host_acc(1'b0, 1'b1, 2'd3, 4'h5, 8'h00);
        chk("b_lane3_novalid", 64'(b_hostRdValid), 64'd0);
        b_host_acc(1'b0, 1'b1, 2'd0, 4'h5, 8'h00);
        chk("b_lane0_valid", 64'(b_hostRdValid), 64'd1);
        chk("b_lane0_data",  64'(b_hostRdData),  64'h3C);

        // DONE -> RUN, then start+procDone together -> DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("relaunch_procStart", 64'(procStart), 64'd1);
        chk("relaunch_finished",  64'(finished),  64'd0);
        start = 1'b1; procDone = 1'b1;
        tick();
        start = 1'b0; procDone = 1'b0;
        chk("both_finished", 64'(finished),  64'd1);
        chk("both_noStart",  64'(procStart), 64'd0);

        // Relaunch, then reset mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        proc_acc(1'b0, 12'h020, 48'h0);
        chk("pre_rst_procIn", 64'(ProcessorDataIn), 64'(P));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("midrun");
        host_acc(1'b0, 1'b1, 2'd0, 12'h020, 12'h000);
        chk("post_rst_valid", 64'(hostRdValid), 64'd1);
        chk("post_rst_020",   64'(hostRdData),  64'h001);
        host_acc(1'b0, 1'b1, 2'd1, 12'h040, 12'h000);
        chk("post_rst_040",   64'(hostRdData),  64'h777);
        chk("post_rst_idle_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
